// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the memory arbiter (state, owner, task payload).
package mem_arbiter_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned TYPE_W = 3;

    // work_type encoding: {unsigned, size[1:0]}
    localparam logic [1:0]  WT_BYTE         = 2'b00;
    localparam logic [1:0]  WT_HALF         = 2'b01;
    localparam logic [1:0]  WT_WORD         = 2'b10;
    localparam int unsigned WT_UNSIGNED_BIT = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LS   = 2'd2
    } owner_e;

    typedef struct packed {
        logic              is_write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [TYPE_W-1:0] wtype;
    } mc_task_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selection between fetch and load-store requesters.
module mem_arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic   if_req,
    input  logic   ls_req,
    input  logic   ls_is_write,
    input  logic   rr_ptr,
    input  logic   rd_allow,
    output owner_e grant
);

    logic if_ok;
    logic ls_ok;

    // rr_ptr=0 favours ls, rr_ptr=1 favours if; stores stay eligible during a flush
    always_comb begin
        if_ok = if_req & rd_allow;
        ls_ok = ls_req & (ls_is_write | rd_allow);
        grant = OWN_NONE;
        if (ls_ok && (!if_ok || !rr_ptr)) begin
            grant = OWN_LS;
        end else if (if_ok) begin
            grant = OWN_IF;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter (fetch, load-store) in front of a single memory controller.
// Optional round-robin priority: define ARB_ROUND_ROBIN_EN.
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              rob_clear,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_data,
    input  logic              ls_req,
    input  logic              ls_is_write,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    input  logic [TYPE_W-1:0] ls_type,
    output logic              ls_done,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              mc_new_task,
    output logic              mc_is_write,
    output logic [ADDR_W-1:0] mc_addr,
    output logic [DATA_W-1:0] mc_wdata,
    output logic [TYPE_W-1:0] mc_type,
    input  logic              mc_ready,
    input  logic              mc_working,
    input  logic [DATA_W-1:0] mc_rdata
);

    state_e   state_q, state_d;
    owner_e   owner_q, owner_d;
    logic     is_write_q, is_write_d;
    logic     flushed_q, flushed_d;
    logic     active_c;
    logic     grant_c;
    logic     done_c;
    logic     rr_ptr_c;
    owner_e   pick_c;
    mc_task_t task_c;

`ifdef ARB_ROUND_ROBIN_EN
    logic rr_q, rr_d;
    assign rr_ptr_c = rr_q;
`else
    assign rr_ptr_c = 1'b0;
`endif

    mem_arb_pick u_pick (
        .if_req      (if_req),
        .ls_req      (ls_req),
        .ls_is_write (ls_is_write),
        .rr_ptr      (rr_ptr_c),
        .rd_allow    (~rob_clear),
        .grant       (pick_c)
    );

    // Next-state and combinational grant / completion
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        is_write_d = is_write_q;
        flushed_d  = flushed_q;
        grant_c    = 1'b0;
        done_c     = 1'b0;
        task_c     = '0;
`ifdef ARB_ROUND_ROBIN_EN
        rr_d       = rr_q;
`endif
        active_c   = rdy_in & ~rst_in;

        if (active_c) begin
            case (state_q)
                ST_IDLE: begin
                    if (!mc_working && pick_c != OWN_NONE) begin
                        grant_c = 1'b1;
                        if (pick_c == OWN_LS) begin
                            task_c.is_write = ls_is_write;
                            task_c.addr     = ls_addr;
                            task_c.wdata    = ls_wdata;
                            task_c.wtype    = ls_type;
                        end else begin
                            task_c.addr     = if_addr;
                            task_c.wtype    = {1'b0, WT_WORD};
                        end
                        state_d    = ST_BUSY;
                        owner_d    = pick_c;
                        is_write_d = task_c.is_write;
                        flushed_d  = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
                        rr_d       = (pick_c == OWN_LS);
`endif
                    end
                end
                ST_BUSY: begin
                    if (is_write_q) begin
                        // writes ignore flushes and finish when the controller goes idle
                        if (!mc_working) begin
                            done_c  = 1'b1;
                            state_d = ST_GAP;
                        end
                    end else if (rob_clear || flushed_q) begin
                        flushed_d = 1'b1;
                        if (!mc_working) begin
                            state_d = ST_GAP;
                        end
                    end else if (mc_ready) begin
                        done_c  = 1'b1;
                        state_d = ST_GAP;
                    end
                end
                ST_GAP: begin
                    state_d    = ST_IDLE;
                    owner_d    = OWN_NONE;
                    is_write_d = 1'b0;
                    flushed_d  = 1'b0;
                end
                default: begin
                    state_d = ST_IDLE;
                    owner_d = OWN_NONE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWN_NONE;
            is_write_q <= 1'b0;
            flushed_q  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            rr_q       <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            is_write_q <= is_write_d;
            flushed_q  <= flushed_d;
`ifdef ARB_ROUND_ROBIN_EN
            rr_q       <= rr_d;
`endif
        end
    end

    assign mc_new_task = grant_c;
    assign mc_is_write = task_c.is_write;
    assign mc_addr     = task_c.addr;
    assign mc_wdata    = task_c.wdata;
    assign mc_type     = task_c.wtype;

    assign if_done  = done_c & (owner_q == OWN_IF);
    assign ls_done  = done_c & (owner_q == OWN_LS);
    assign if_data  = if_done ? mc_rdata : '0;
    assign ls_rdata = (ls_done && !is_write_q) ? mc_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; expectations are hand-computed per cycle.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, rob_clear;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        ls_req, ls_is_write;
    logic [31:0] ls_addr, ls_wdata;
    logic [2:0]  ls_type;
    logic        ls_done;
    logic [31:0] ls_rdata;
    logic        mc_new_task, mc_is_write;
    logic [31:0] mc_addr, mc_wdata;
    logic [2:0]  mc_type;
    logic        mc_ready, mc_working;
    logic [31:0] mc_rdata;

    int errs   = 0;
    int checks = 0;

    always #5 clk_in = ~clk_in;

    mem_arbiter dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rdy_in      (rdy_in),
        .rob_clear   (rob_clear),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_done     (if_done),
        .if_data     (if_data),
        .ls_req      (ls_req),
        .ls_is_write (ls_is_write),
        .ls_addr     (ls_addr),
        .ls_wdata    (ls_wdata),
        .ls_type     (ls_type),
        .ls_done     (ls_done),
        .ls_rdata    (ls_rdata),
        .mc_new_task (mc_new_task),
        .mc_is_write (mc_is_write),
        .mc_addr     (mc_addr),
        .mc_wdata    (mc_wdata),
        .mc_type     (mc_type),
        .mc_ready    (mc_ready),
        .mc_working  (mc_working),
        .mc_rdata    (mc_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // inputs change 1 time unit after the rising edge; checks happen at the falling edge
    task automatic next_cycle();
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; rob_clear = 1'b0;
        if_req = 1'b1; if_addr = 32'h1000;
        ls_req = 1'b0; ls_is_write = 1'b0; ls_addr = '0; ls_wdata = '0; ls_type = 3'b010;
        mc_ready = 1'b0; mc_working = 1'b0; mc_rdata = '0;

        // reset with a fetch request held high
        next_cycle(); #4;
        chk("rst_no_grant", 32'(mc_new_task), 0);
        next_cycle(); #4;
        chk("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
        chk("rst_if_done", 32'(if_done), 0);

        // fetch only: t0 issue, ready at t0+4
        next_cycle(); rst_in = 1'b0; #4;
        chk("f_issue", 32'(mc_new_task), 1);
        chk("f_addr", mc_addr, 32'h1000);
        chk("f_type", 32'(mc_type), 32'h2);
        chk("f_is_write", 32'(mc_is_write), 0);
        for (int i = 1; i <= 3; i++) begin
            next_cycle(); if_req = 1'b0; mc_working = 1'b1; #4;
            chk("f_wait_done", 32'(if_done), 0);
            chk("f_wait_nt", 32'(mc_new_task), 0);
        end
        next_cycle(); mc_ready = 1'b1; mc_rdata = 32'h13; #4;
        chk("f_done", 32'(if_done), 1);
        chk("f_data", if_data, 32'h13);
        next_cycle(); mc_ready = 1'b0; mc_working = 1'b0; mc_rdata = '0;
        if_req = 1'b1; if_addr = 32'h1004; #4;
        chk("gap_state", 32'(dut.state_q), 32'(ST_GAP));
        chk("gap_no_grant", 32'(mc_new_task), 0);
        next_cycle(); #4;
        chk("f2_issue_t6", 32'(mc_new_task), 1);
        chk("f2_addr", mc_addr, 32'h1004);
        next_cycle(); if_req = 1'b0; mc_ready = 1'b1; mc_rdata = 32'h55; #4;
        chk("f2_done", 32'(if_done), 1);
        chk("f2_data", if_data, 32'h55);
        next_cycle(); mc_ready = 1'b0; #4;

        // collision A: ls load wins, then if alone after the gap
        next_cycle(); if_req = 1'b1; if_addr = 32'h1008;
        ls_req = 1'b1; ls_addr = 32'h2000; ls_type = 3'b010; #4;
        chk("colA_grant", mc_addr, 32'h2000);
        next_cycle(); ls_req = 1'b0; mc_ready = 1'b1; mc_rdata = 32'hAA; #4;
        chk("colA_ls_done", 32'(ls_done), 1);
        chk("colA_ls_rdata", ls_rdata, 32'hAA);
        chk("colA_if_done", 32'(if_done), 0);
        next_cycle(); mc_ready = 1'b0; #4;
        chk("colA_gap_nt", 32'(mc_new_task), 0);
        next_cycle(); #4;
        chk("colA_if_grant", mc_addr, 32'h1008);
        next_cycle(); if_req = 1'b0; mc_ready = 1'b1; mc_rdata = 32'h77; #4;
        chk("colA_if_done2", 32'(if_done), 1);
        next_cycle(); mc_ready = 1'b0; #4;

        // collision C then D: D tells fixed priority from round robin
        next_cycle(); if_req = 1'b1; if_addr = 32'h100C; ls_req = 1'b1; ls_addr = 32'h2004; #4;
        chk("colC_grant", mc_addr, 32'h2004);
        next_cycle(); ls_req = 1'b0; mc_ready = 1'b1; mc_rdata = 32'hBB; #4;
        chk("colC_ls_done", 32'(ls_done), 1);
        next_cycle(); mc_ready = 1'b0; #4;
        next_cycle(); ls_req = 1'b1; ls_addr = 32'h2008; #4;
`ifdef ARB_ROUND_ROBIN_EN
        chk("colD_grant", mc_addr, 32'h100C);
`else
        chk("colD_grant", mc_addr, 32'h2008);
`endif
        next_cycle(); ls_req = 1'b0; if_req = 1'b0; mc_ready = 1'b1; mc_rdata = 32'hCC; #4;
`ifdef ARB_ROUND_ROBIN_EN
        chk("colD_done", {30'd0, if_done, ls_done}, 32'h2);
`else
        chk("colD_done", {30'd0, if_done, ls_done}, 32'h1);
`endif
        next_cycle(); mc_ready = 1'b0; #4;

        // byte store, controller never busy
        next_cycle(); ls_req = 1'b1; ls_is_write = 1'b1; ls_type = 3'b000;
        ls_addr = 32'h30000; ls_wdata = 32'h5A; #4;
        chk("bs_issue", 32'(mc_new_task), 1);
        chk("bs_is_write", 32'(mc_is_write), 1);
        chk("bs_type", 32'(mc_type), 0);
        chk("bs_wdata", mc_wdata, 32'h5A);
        next_cycle(); ls_req = 1'b0; #4;
        chk("bs_done", 32'(ls_done), 1);
        chk("bs_rdata", ls_rdata, 0);
        next_cycle(); #4;
        chk("bs_gap_done", 32'(ls_done), 0);

        // flush: no read granted during rob_clear, then fetch flushed at issue+1
        next_cycle(); ls_is_write = 1'b0; ls_type = 3'b010; ls_req = 1'b1; ls_addr = 32'h2010;
        if_req = 1'b1; if_addr = 32'h1010; rob_clear = 1'b1; #4;
        chk("fl_no_read_grant", 32'(mc_new_task), 0);
        next_cycle(); rob_clear = 1'b0; ls_req = 1'b0; #4;
        chk("fl_issue", mc_addr, 32'h1010);
        next_cycle(); if_req = 1'b0; rob_clear = 1'b1; mc_working = 1'b1; #4;
        chk("fl_done1", 32'(if_done), 0);
        next_cycle(); rob_clear = 1'b0; mc_ready = 1'b1; mc_rdata = 32'h99; #4;
        chk("fl_done2", 32'(if_done), 0);
        next_cycle(); mc_ready = 1'b0; #4;
        chk("fl_busy", 32'(dut.state_q), 32'(ST_BUSY));
        next_cycle(); mc_working = 1'b0; #4;
        chk("fl_done3", 32'(if_done), 0);
        next_cycle(); #4;
        chk("fl_gap", 32'(dut.state_q), 32'(ST_GAP));
        next_cycle(); #4;
        chk("fl_idle", 32'(dut.state_q), 32'(ST_IDLE));

        // word store issued and continued under rob_clear
        next_cycle(); ls_req = 1'b1; ls_is_write = 1'b1; ls_type = 3'b010;
        ls_addr = 32'h30004; ls_wdata = 32'hDEADBEEF; rob_clear = 1'b1; #4;
        chk("ws_issue", 32'(mc_new_task), 1);
        chk("ws_wdata", mc_wdata, 32'hDEADBEEF);
        next_cycle(); ls_req = 1'b0; mc_working = 1'b1; #4;
        chk("ws_wait1", 32'(ls_done), 0);
        next_cycle(); rob_clear = 1'b0; #4;
        chk("ws_wait2", 32'(ls_done), 0);
        next_cycle(); mc_working = 1'b0; #4;
        chk("ws_done", 32'(ls_done), 1);
        next_cycle(); ls_is_write = 1'b0; #4;

        // mc_ready and rob_clear together: flushed
        next_cycle(); if_req = 1'b1; if_addr = 32'h1020; #4;
        chk("rc_issue", 32'(mc_new_task), 1);
        next_cycle(); if_req = 1'b0; mc_ready = 1'b1; rob_clear = 1'b1; mc_rdata = 32'h11; #4;
        chk("rc_no_done", 32'(if_done), 0);
        next_cycle(); mc_ready = 1'b0; rob_clear = 1'b0; #4;
        chk("rc_gap", 32'(dut.state_q), 32'(ST_GAP));

        // rdy_in low for 3 cycles during BUSY
        next_cycle(); ls_req = 1'b1; ls_addr = 32'h2010; ls_type = 3'b100; #4;
        chk("rdy_issue_type", 32'(mc_type), 32'h4);
        next_cycle(); ls_req = 1'b0; mc_working = 1'b1; rdy_in = 1'b0;
        mc_ready = 1'b1; mc_rdata = 32'h44; #4;
        chk("rdy_low_done0", 32'(ls_done), 0);
        next_cycle(); #4;
        chk("rdy_low_done1", 32'(ls_done), 0);
        next_cycle(); #4;
        chk("rdy_low_done2", 32'(ls_done), 0);
        next_cycle(); rdy_in = 1'b1; #4;
        chk("rdy_back_done", 32'(ls_done), 1);
        chk("rdy_back_rdata", ls_rdata, 32'h44);
        next_cycle(); mc_ready = 1'b0; mc_working = 1'b0; #4;

        // reset mid-BUSY with a request held
        next_cycle(); if_req = 1'b1; if_addr = 32'h1030; #4;
        chk("mr_issue", 32'(mc_new_task), 1);
        next_cycle(); mc_working = 1'b1; rst_in = 1'b1; #4;
        chk("mr_nt", 32'(mc_new_task), 0);
        next_cycle(); #4;
        chk("mr_state", 32'(dut.state_q), 32'(ST_IDLE));
        chk("mr_nt2", 32'(mc_new_task), 0);
        chk("mr_addr", mc_addr, 0);
        chk("mr_dones", {30'd0, if_done, ls_done}, 0);
        chk("mr_if_data", if_data, 0);
        next_cycle(); rst_in = 1'b0; mc_working = 1'b0; #4;
        chk("mr_regrant", 32'(mc_new_task), 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 clk_in  input  1  system clock; all state changes on its rising edge.
REQ-002 rst_in  input  1  reset; synchronous, active-high.
REQ-003 rdy_in  input  1  global enable; when low, all state is frozen and mc_new_task is 0.
REQ-004 rob_clear  input  1  pipeline flush.
REQ-005 if_req / if_addr  input  1/32  instruction-fetch request and word address; read only, type fixed to word (3'b010).
REQ-006 if_done / if_data  output  1/32  fetch completion pulse and its data.
REQ-007 ls_req / ls_is_write / ls_addr / ls_wdata / ls_type  input  1/1/32/32/3  load-store request; ls_type = {unsigned, size[1:0]}, with size 00 byte, 01 half, 10 word.
REQ-008 ls_done / ls_rdata  output  1/32  load-store completion pulse and read data.
REQ-009 mc_new_task / mc_is_write / mc_addr / mc_wdata / mc_type  output  1/1/32/32/3  task issue to the memory controller.
REQ-010 mc_ready / mc_working / mc_rdata  input  1/1/32  controller read-ready, busy flag and read data.

Function
REQ-011 The arbiter SHALL use three states: IDLE, BUSY and GAP.
REQ-012 In IDLE with rdy_in=1 and mc_working=0, it SHALL grant one pending request combinationally: mc_new_task=1 and the mc_* fields are driven from the winner in the same cycle. The state becomes BUSY at the next edge, with the owner and direction latched.
REQ-013 Default priority SHALL be fixed: ls over if.
REQ-014 In IDLE with rob_clear=1, it SHALL NOT grant a read (if, or ls load); an ls store MAY be granted.
REQ-015 A read completes in BUSY when mc_ready=1.
  - if_done or ls_done pulses for exactly that cycle.
  - if_data / ls_rdata = mc_rdata, passed combinationally.
  - The state becomes GAP.
REQ-016 A write completes in BUSY at the first cycle with mc_working=0; the owner's done pulses for that cycle and the state becomes GAP. A byte write therefore completes 1 cycle after issue.
REQ-017 GAP SHALL last exactly one cycle and return to IDLE without granting; requesters drop req during GAP.
REQ-018 rob_clear=1 while BUSY with a read SHALL mark the read flushed.
  - No done pulse is produced.
  - The state becomes GAP once mc_working=0.
REQ-019 rob_clear while BUSY with a write SHALL NOT affect it; the write completes per REQ-016.
REQ-020 If mc_ready and rob_clear are both 1 in the same cycle during a read, the read SHALL be treated as flushed (no done).
REQ-021 Done outputs SHALL be 0 whenever rdy_in=0; the completion is taken on the first cycle after rdy_in returns high with its condition met.
REQ-022 mc_new_task SHALL never be high in BUSY or GAP, and SHALL never be high two cycles in a row.

Reset
REQ-023 With rst_in=1, the state SHALL be IDLE, the owner and flushed flags cleared, and all outputs 0 from the next cycle onward, including a reset asserted mid-operation.
REQ-024 A request held high through reset SHALL be granted no earlier than the first cycle after rst_in falls.

Configuration
REQ-025 With ARB_ROUND_ROBIN_EN defined, the granted side's priority SHALL drop below the other's after each grant. Without it, REQ-013 fixed priority applies.
REQ-026 The round-robin pointer SHALL reset to favour ls.

Structure
REQ-027 A shared package SHALL hold:
  - the state enum;
  - the owner encoding (NONE, IF, LS);
  - width constants;
  - work_type constants: BYTE 2'b00, HALF 2'b01, WORD 2'b10, UNSIGNED bit 2.
REQ-028 Grant selection SHALL be a combinational sub-module, mem_arb_pick (inputs: two reqs, pointer, read-allowed; output: grant).

Verification
REQ-029 Fetch only: if_req=1, if_addr=0x1000, mc_ready pulses 4 cycles after issue with mc_rdata=0x00000013 -> mc_new_task at t0, if_done and if_data=0x13 at t0+4, mc_new_task not re-asserted until t0+6.
REQ-030 Collision: if_req and ls_req both high, ls a load of 0x2000 -> ls is granted first; if is granted on the first IDLE after GAP. Under ARB_ROUND_ROBIN_EN, a second collision then grants if.
REQ-031 Byte store: ls_is_write=1, ls_type=3'b000, ls_addr=0x30000, mc_working stays 0 -> ls_done 1 cycle after issue.
REQ-032 Flush: a fetch in flight and rob_clear pulsed at issue+1 -> no if_done ever; the state returns to IDLE after mc_working falls.
REQ-033 Word store with rob_clear mid-way -> ls_done still pulses when mc_working falls.
REQ-034 rdy_in held low 3 cycles during BUSY, and rst_in asserted mid-BUSY -> no done while rdy_in is low; all outputs are 0 and the state is IDLE the cycle after reset.
